rob_commit_unit: RTL and testbench
==================================

Name: rob_commit_unit

Overview:
- Retire-side consumer of the reorder buffer.
- Watches the ROB head (instr/val/ready/empty) and decides how each completed instruction retires: register-file write, store release to the store buffer, or retire-only.
- Issues the one-cycle pop back to the ROB, so architectural state updates strictly in program order. Sits between the ROB and the architectural regfile / store buffer.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)
RF_AW, 5, register-file address width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset; all state and outputs clear immediately on assertion
commit_en  in  1  permission to start retiring a new head entry; does not abort an in-flight store
rob_empty  in  1  ROB is_empty
rob_head_instr  in  32  ROB head_instr (0 = no valid entry)
rob_head_val  in  32  ROB head_val (result value)
rob_head_ready  in  1  ROB head_ready
rob_pop  out  1  one-cycle pop pulse to ROB
rf_wEn  out  1  regfile write enable, one cycle
rf_waddr  out  RF_AW  regfile write address
rf_wdata  out  32  regfile write data
st_req  out  1  store-release request to store buffer
st_instr  out  32  instruction word of the store being released (tag)
st_ack  in  1  store buffer accepted release
retired_count  out  CNT_W  total instructions retired
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: state=IDLE; rob_pop, rf_wEn, st_req, busy = 0; rf_waddr, rf_wdata, st_instr, retired_count = 0. Deassertion takes effect on the next clock edge.
- Decode fields: opcode = instr[31:27], rd = instr[26:22].
- Store: opcode 00111.
- No-dest: opcodes 00001 (j), 00010 (bne), 00100 (jr), 00110 (blt), 10110 (bex).
- Fixed dest: 00011 (jal) writes r31; 10101 (setx) writes r30.
- All other opcodes write rd.
- Any write with address 0 is suppressed (rf_wEn=0), but the instruction still retires.
- Head is eligible iff !rob_empty & rob_head_ready & (rob_head_instr != 0).
- IDLE:
  - If eligible & commit_en and opcode is a store: go to ST_WAIT; register st_req=1 and st_instr=head_instr.
  - If eligible & commit_en otherwise: go to RETIRE; register rob_pop=1, rf_wEn per decode, rf_waddr, rf_wdata=rob_head_val.
  - Else: stay in IDLE with all pulses low.
- ST_WAIT:
  - Hold st_req=1 and st_instr stable until st_ack is sampled high.
  - On that edge: st_req=0, go to RETIRE with rob_pop=1, rf_wEn=0.
  - commit_en low has no effect in this state.
  - st_ack while not in ST_WAIT is ignored.
- RETIRE:
  - Outputs asserted for exactly this one cycle; retired_count increments on the exiting edge; next state IDLE.
  - IDLE re-samples the head the cycle after RETIRE, because the ROB head shifts on the pop edge.
- Latency: an eligible non-store head sampled at edge N gives rob_pop/rf_wEn high in cycle N..N+1, back in IDLE after N+1. Peak throughput is 1 retire per 2 cycles.
- Store latency is 2 cycles plus ack wait.
- rob_pop is never asserted unless head_ready was high when the entry was latched. The pop is a single-cycle pulse; never two consecutive cycles.
- retired_count wraps to 0 after all-ones with no flag.
- Reset asserted in ST_WAIT or RETIRE drops st_req/rob_pop/rf_wEn asynchronously; the partially retired entry remains in the ROB.

Test Plan:
- Reset: reset=0 with garbage inputs -> every output 0, busy=0; release reset with rob_empty=1 -> stays IDLE for 10 cycles, no pulses.
- ALU retire: head instr=0x00C00000 (opcode 0, rd=3), val=0xDEADBEEF, ready=1, commit_en=1 -> next cycle rob_pop=1, rf_wEn=1, rf_waddr=3, rf_wdata=0xDEADBEEF, one cycle only; retired_count=1.
- Dest decode: jal (0x18000010) val=0x44 -> rf_waddr=31, wdata=0x44; bne (0x10000004) -> rob_pop=1, rf_wEn=0; rd=0 ALU op -> rf_wEn=0, count increments.
- Store handshake: head sw 0x38000000 ready -> st_req=1, st_instr=0x38000000; hold st_ack=0 for 5 cycles -> st_req stays 1, rob_pop=0; st_ack=1 -> next cycle rob_pop=1, st_req=0, rf_wEn=0.
- Gating: head ready but commit_en=0 -> no pop; head_ready=0 -> no pop; head_instr=0 with ready=1 -> no pop; commit_en drop during ST_WAIT -> store still completes on ack.
- Back-to-back and wrap: 4 ready ALU heads -> pops in cycles 1,3,5,7; preload retired_count at all-ones via 2^CNT_W-1 retires (CNT_W=4 build) -> next retire gives 0; reset asserted mid-ST_WAIT -> st_req=0 immediately.

Source files
------------

// File: rtl/rob_commit_unit.sv
// Retire-side consumer of the reorder buffer: retires the ROB head in program order
// via a register write, a store release to the store buffer, or a plain retire.
module rob_commit_unit #(
  parameter int CNT_W = 32,
  parameter int RF_AW = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             commit_en,
  input  logic             rob_empty,
  input  logic [31:0]      rob_head_instr,
  input  logic [31:0]      rob_head_val,
  input  logic             rob_head_ready,
  output logic             rob_pop,
  output logic             rf_wEn,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             st_req,
  output logic [31:0]      st_instr,
  input  logic             st_ack,
  output logic [CNT_W-1:0] retired_count,
  output logic             busy
);

  // state   | meaning
  // IDLE    | sampling the ROB head for an eligible, permitted entry
  // ST_WAIT | store release requested, waiting for st_ack
  // RETIRE  | one-cycle pop (and optional regfile write) back to the ROB
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_WAIT = 2'd1,
    RETIRE  = 2'd2
  } state_t;

  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  state_t           state;
  logic [4:0]       opcode;
  logic [4:0]       rd;
  logic             eligible;
  logic             is_store;
  logic             has_dest;
  logic [RF_AW-1:0] dest_addr;
  logic             dest_wen;

  assign opcode   = rob_head_instr[31:27];
  assign rd       = rob_head_instr[26:22];
  assign eligible = !rob_empty && rob_head_ready && (rob_head_instr != 32'd0);
  assign is_store = (opcode == OP_SW);

  always_comb begin
    has_dest  = 1'b1;
    dest_addr = RF_AW'(rd);
    case (opcode)
      OP_J, OP_BNE, OP_JR, OP_BLT, OP_BEX, OP_SW: has_dest = 1'b0;
      OP_JAL:  dest_addr = RF_AW'(5'd31);
      OP_SETX: dest_addr = RF_AW'(5'd30);
      default: ;
    endcase
    // r0 is hardwired zero: the instruction retires but never writes.
    dest_wen = has_dest && (dest_addr != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rob_pop       <= 1'b0;
      rf_wEn        <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      st_req        <= 1'b0;
      st_instr      <= '0;
      retired_count <= '0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rob_pop <= 1'b0;
          rf_wEn  <= 1'b0;
          st_req  <= 1'b0;
          if (eligible && commit_en) begin
            busy <= 1'b1;
            if (is_store) begin
              state    <= ST_WAIT;
              st_req   <= 1'b1;
              st_instr <= rob_head_instr;
            end else begin
              state    <= RETIRE;
              rob_pop  <= 1'b1;
              rf_wEn   <= dest_wen;
              rf_waddr <= dest_addr;
              rf_wdata <= rob_head_val;
            end
          end
        end
        ST_WAIT: begin
          if (st_ack) begin
            state   <= RETIRE;
            st_req  <= 1'b0;
            rob_pop <= 1'b1;
            rf_wEn  <= 1'b0;
          end
        end
        RETIRE: begin
          state         <= IDLE;
          rob_pop       <= 1'b0;
          rf_wEn        <= 1'b0;
          busy          <= 1'b0;
          retired_count <= retired_count + 1'b1;
        end
        default: begin
          state   <= IDLE;
          rob_pop <= 1'b0;
          rf_wEn  <= 1'b0;
          st_req  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit; a CNT_W=4 twin shares all inputs to exercise counter wrap.
module tb_rob_commit_unit;

  logic        clock;
  logic        reset;
  logic        commit_en;
  logic        rob_empty;
  logic [31:0] rob_head_instr;
  logic [31:0] rob_head_val;
  logic        rob_head_ready;
  logic        st_ack;

  logic        rob_pop, rf_wEn, st_req, busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, st_instr;
  logic [31:0] retired_count;

  logic        n_rob_pop, n_rf_wEn, n_st_req, n_busy;
  logic [4:0]  n_rf_waddr;
  logic [31:0] n_rf_wdata, n_st_instr;
  logic [3:0]  n_retired_count;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  rob_commit_unit dut (
    .clock(clock), .reset(reset), .commit_en(commit_en), .rob_empty(rob_empty),
    .rob_head_instr(rob_head_instr), .rob_head_val(rob_head_val),
    .rob_head_ready(rob_head_ready), .rob_pop(rob_pop), .rf_wEn(rf_wEn),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .st_req(st_req), .st_instr(st_instr),
    .st_ack(st_ack), .retired_count(retired_count), .busy(busy)
  );

  rob_commit_unit #(.CNT_W(4)) dut_n (
    .clock(clock), .reset(reset), .commit_en(commit_en), .rob_empty(rob_empty),
    .rob_head_instr(rob_head_instr), .rob_head_val(rob_head_val),
    .rob_head_ready(rob_head_ready), .rob_pop(n_rob_pop), .rf_wEn(n_rf_wEn),
    .rf_waddr(n_rf_waddr), .rf_wdata(n_rf_wdata), .st_req(n_st_req), .st_instr(n_st_instr),
    .st_ack(st_ack), .retired_count(n_retired_count), .busy(n_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_head(input logic [31:0] instr, input logic [31:0] val);
    rob_empty      = 1'b0;
    rob_head_instr = instr;
    rob_head_val   = val;
    rob_head_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    commit_en = 1'b1; rob_empty = 1'b0; rob_head_instr = 32'h38000000;
    rob_head_val = 32'hFFFFFFFF; rob_head_ready = 1'b1; st_ack = 1'b1;
    #3;
    checks++;
    if ({rob_pop, rf_wEn, st_req, busy, rf_waddr, rf_wdata, st_instr, retired_count} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: pop=%b wen=%b st_req=%b busy=%b waddr=%0d wdata=%h st_instr=%h cnt=%0d, required all 0",
               rob_pop, rf_wEn, st_req, busy, rf_waddr, rf_wdata, st_instr, retired_count);
    end
    tick();
    tick();
    rob_empty = 1'b1; st_ack = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({rob_pop, rf_wEn, st_req, busy} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: pop=%b wen=%b st_req=%b busy=%b, required 0", i, rob_pop, rf_wEn, st_req, busy);
      end
    end
  endtask

  task automatic test_alu_retire();
    set_head(32'h00C00000, 32'hDEADBEEF);
    commit_en = 1'b1;
    tick();
    checks++;
    if ({rob_pop, rf_wEn, busy} !== 3'b111 || rf_waddr !== 5'd3 || rf_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL alu_retire: pop=%b wen=%b busy=%b waddr=%0d wdata=%h, required 1 1 1 3 deadbeef",
               rob_pop, rf_wEn, busy, rf_waddr, rf_wdata);
    end
    rob_empty = 1'b1;
    tick();
    exp_cnt++;
    checks++;
    if ({rob_pop, rf_wEn, busy} !== 3'b000 || retired_count !== 32'(exp_cnt)) begin
      failures++;
      $display("FAIL alu_after: pop=%b wen=%b busy=%b cnt=%0d, required 0 0 0 %0d", rob_pop, rf_wEn, busy, retired_count, exp_cnt);
    end
  endtask

  task automatic test_dest_decode();
    logic [31:0] instrs [4] = '{32'h18000010, 32'h10000004, 32'h00000001, 32'hA8000005};
    logic [31:0] vals   [4] = '{32'h00000044, 32'h12345678, 32'h0000BEEF, 32'h00000777};
    logic        wens   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [4:0]  addrs  [4] = '{5'd31, 5'd0, 5'd0, 5'd30};
    for (int i = 0; i < 4; i++) begin
      set_head(instrs[i], vals[i]);
      tick();
      checks++;
      if (rob_pop !== 1'b1 || rf_wEn !== wens[i] || (wens[i] && (rf_waddr !== addrs[i] || rf_wdata !== vals[i]))) begin
        failures++;
        $display("FAIL decode %h: pop=%b wen=%b waddr=%0d wdata=%h, required 1 %b %0d %h",
                 instrs[i], rob_pop, rf_wEn, rf_waddr, rf_wdata, wens[i], addrs[i], vals[i]);
      end
      rob_empty = 1'b1;
      tick();
      exp_cnt++;
      checks++;
      if (retired_count !== 32'(exp_cnt) || rob_pop !== 1'b0) begin
        failures++;
        $display("FAIL decode_count %h: cnt=%0d pop=%b, required %0d 0", instrs[i], retired_count, rob_pop, exp_cnt);
      end
    end
  endtask

  task automatic test_store();
    set_head(32'h38000000, 32'h0);
    tick();
    checks++;
    if (st_req !== 1'b1 || st_instr !== 32'h38000000 || rob_pop !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL store_req: st_req=%b st_instr=%h pop=%b busy=%b, required 1 38000000 0 1", st_req, st_instr, rob_pop, busy);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (st_req !== 1'b1 || st_instr !== 32'h38000000 || rob_pop !== 1'b0) begin
        failures++;
        $display("FAIL store_hold %0d: st_req=%b st_instr=%h pop=%b, required 1 38000000 0", i, st_req, st_instr, rob_pop);
      end
    end
    st_ack = 1'b1;
    tick();
    checks++;
    if (rob_pop !== 1'b1 || st_req !== 1'b0 || rf_wEn !== 1'b0) begin
      failures++;
      $display("FAIL store_ack: pop=%b st_req=%b wen=%b, required 1 0 0", rob_pop, st_req, rf_wEn);
    end
    st_ack = 1'b0; rob_empty = 1'b1;
    tick();
    exp_cnt++;
    checks++;
    if (rob_pop !== 1'b0 || busy !== 1'b0 || retired_count !== 32'(exp_cnt)) begin
      failures++;
      $display("FAIL store_done: pop=%b busy=%b cnt=%0d, required 0 0 %0d", rob_pop, busy, retired_count, exp_cnt);
    end
  endtask

  task automatic test_gating();
    set_head(32'h00C00000, 32'h1);
    commit_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rob_pop !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL gate_commit_en: pop=%b busy=%b, required 0 0", rob_pop, busy);
      end
    end
    commit_en = 1'b1; rob_head_ready = 1'b0;
    tick(); tick();
    checks++;
    if (rob_pop !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL gate_not_ready: pop=%b busy=%b, required 0 0", rob_pop, busy);
    end
    rob_head_ready = 1'b1; rob_head_instr = 32'h0;
    tick(); tick();
    checks++;
    if (rob_pop !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL gate_zero_instr: pop=%b busy=%b, required 0 0", rob_pop, busy);
    end
    rob_empty = 1'b1; st_ack = 1'b1;
    tick(); tick();
    checks++;
    if (rob_pop !== 1'b0 || st_req !== 1'b0 || retired_count !== 32'(exp_cnt)) begin
      failures++;
      $display("FAIL gate_stray_ack: pop=%b st_req=%b cnt=%0d, required 0 0 %0d", rob_pop, st_req, retired_count, exp_cnt);
    end
    st_ack = 1'b0;
    set_head(32'h38400000, 32'h0);
    tick();
    commit_en = 1'b0;
    tick(); tick();
    checks++;
    if (st_req !== 1'b1 || st_instr !== 32'h38400000) begin
      failures++;
      $display("FAIL gate_st_hold: st_req=%b st_instr=%h, required 1 38400000", st_req, st_instr);
    end
    st_ack = 1'b1;
    tick();
    checks++;
    if (rob_pop !== 1'b1 || st_req !== 1'b0) begin
      failures++;
      $display("FAIL gate_st_complete: pop=%b st_req=%b, required 1 0", rob_pop, st_req);
    end
    st_ack = 1'b0; rob_empty = 1'b1; commit_en = 1'b1;
    tick();
    exp_cnt++;
  endtask

  task automatic test_back_to_back();
    set_head(32'h01000000, 32'hA5A5A5A5);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (rob_pop !== 1'((i % 2) == 1)) begin
        failures++;
        $display("FAIL b2b cycle %0d: pop=%b, required %b", i, rob_pop, 1'((i % 2) == 1));
      end
    end
    rob_empty = 1'b1;
    exp_cnt += 4;
    checks++;
    if (retired_count !== 32'(exp_cnt)) begin
      failures++;
      $display("FAIL b2b_count: cnt=%0d, required %0d", retired_count, exp_cnt);
    end
  endtask

  task automatic test_wrap();
    set_head(32'h01400000, 32'h5);
    while (exp_cnt < 15) begin
      tick(); tick();
      exp_cnt++;
    end
    rob_empty = 1'b1;
    checks++;
    if (n_retired_count !== 4'hF) begin
      failures++;
      $display("FAIL wrap_allones: cnt=%0d, required 15", n_retired_count);
    end
    rob_empty = 1'b0;
    tick();
    rob_empty = 1'b1;
    tick();
    exp_cnt++;
    checks++;
    if (n_retired_count !== 4'h0 || retired_count !== 32'(exp_cnt)) begin
      failures++;
      $display("FAIL wrap_zero: narrow=%0d wide=%0d, required 0 %0d", n_retired_count, retired_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_store();
    set_head(32'h38000000, 32'h0);
    tick();
    checks++;
    if (st_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_setup: st_req=%b, required 1", st_req);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (st_req !== 1'b0 || busy !== 1'b0 || st_instr !== 32'h0 || retired_count !== 32'h0) begin
      failures++;
      $display("FAIL rst_mid_store: st_req=%b busy=%b st_instr=%h cnt=%0d, required 0 0 0 0",
               st_req, busy, st_instr, retired_count);
    end
    tick();
    reset = 1'b1; rob_empty = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_retire();
    test_dest_decode();
    test_store();
    test_gating();
    test_back_to_back();
    test_wrap();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
